// File: rtl/ge_addsub_p.sv
`default_nettype none
// ============================================================================
//  Module   : ge_addsub_p
//  Purpose  : Extended-point plus cached-point add/subtract for twisted
//             Edwards curves, producing the P1P1 completed form. Field
//             multiplications are delegated to an external multiplier over
//             a req/ack handshake; field add/sub are done locally.
//  Revision : 1.0  initial release
// ============================================================================
module ge_addsub_p #(
    parameter int          W = 255,
    parameter logic [W-1:0] P = {W{1'b1}} - W'(18)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] p_x,
    input  logic [W-1:0] p_y,
    input  logic [W-1:0] p_z,
    input  logic [W-1:0] p_t,
    input  logic [W-1:0] q_yplusx,
    input  logic [W-1:0] q_yminusx,
    input  logic [W-1:0] q_t2d,
    input  logic [W-1:0] q_z,
    output logic         mul_req,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic         mul_ack,
    input  logic [W-1:0] mul_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r_x,
    output logic [W-1:0] r_y,
    output logic [W-1:0] r_z,
    output logic [W-1:0] r_t
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        PRE  = 4'd1,
        MUL0 = 4'd2,
        MUL1 = 4'd3,
        MUL2 = 4'd4,
        MUL3 = 4'd5,
        FIN1 = 4'd6,
        FIN2 = 4'd7,
        DONE = 4'd8
    } state_t;

    // Modular add: one extra bit catches the carry, at most one reduction
    // is needed because both operands are already reduced.
    function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[W-1:0];
    endfunction

    // Modular subtract: the borrow bit flags a negative result.
    function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) begin
            d = d + {1'b0, P};
        end
        return d[W-1:0];
    endfunction

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   px_q, px_d, py_q, py_d, pz_q, pz_d, pt_q, pt_d;
    logic [W-1:0]   qyp_q, qyp_d, qym_q, qym_d, qt2d_q, qt2d_d, qz_q, qz_d;
    logic [W-1:0]   ypx_q, ypx_d, ymx_q, ymx_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, d2_q, d2_d;
    logic [W-1:0]   rx_q, rx_d, ry_q, ry_d, rz_q, rz_d, rt_q, rt_d;
    logic           mul_req_q, mul_req_d;
    logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;

    // An ack only counts after the request cycle of the current MUL state.
    logic           w_ack;
    assign w_ack = mul_ack && !mul_req_q;

    // Next-state and datapath: each transition into a MUL state launches the
    // next multiplication so mul_req always lands on that state's first cycle.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        px_d      = px_q;
        py_d      = py_q;
        pz_d      = pz_q;
        pt_d      = pt_q;
        qyp_d     = qyp_q;
        qym_d     = qym_q;
        qt2d_d    = qt2d_q;
        qz_d      = qz_q;
        ypx_d     = ypx_q;
        ymx_d     = ymx_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        d2_d      = d2_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        rz_d      = rz_q;
        rt_d      = rt_q;
        mul_req_d = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    px_d    = p_x;
                    py_d    = p_y;
                    pz_d    = p_z;
                    pt_d    = p_t;
                    qyp_d   = q_yplusx;
                    qym_d   = q_yminusx;
                    qt2d_d  = q_t2d;
                    qz_d    = q_z;
                    state_d = PRE;
                end
            end
            PRE: begin
                ypx_d     = f_add(py_q, px_q);
                ymx_d     = f_sub(py_q, px_q);
                mul_a_d   = ypx_d;
                mul_b_d   = mode_q ? qym_q : qyp_q;
                mul_req_d = 1'b1;
                state_d   = MUL0;
            end
            MUL0: begin
                if (w_ack) begin
                    a_d       = mul_res;
                    mul_a_d   = ymx_q;
                    mul_b_d   = mode_q ? qyp_q : qym_q;
                    mul_req_d = 1'b1;
                    state_d   = MUL1;
                end
            end
            MUL1: begin
                if (w_ack) begin
                    b_d       = mul_res;
                    mul_a_d   = qt2d_q;
                    mul_b_d   = pt_q;
                    mul_req_d = 1'b1;
                    state_d   = MUL2;
                end
            end
            MUL2: begin
                if (w_ack) begin
                    c_d       = mul_res;
                    mul_a_d   = pz_q;
                    mul_b_d   = qz_q;
                    mul_req_d = 1'b1;
                    state_d   = MUL3;
                end
            end
            MUL3: begin
                if (w_ack) begin
                    d_d     = mul_res;
                    state_d = FIN1;
                end
            end
            FIN1: begin
                rx_d    = f_sub(a_q, b_q);
                ry_d    = f_add(a_q, b_q);
                d2_d    = f_add(d_q, d_q);
                state_d = FIN2;
            end
            FIN2: begin
                rz_d    = mode_q ? f_sub(d2_q, c_q) : f_add(d2_q, c_q);
                rt_d    = mode_q ? f_add(d2_q, c_q) : f_sub(d2_q, c_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
            pt_q      <= '0;
            qyp_q     <= '0;
            qym_q     <= '0;
            qt2d_q    <= '0;
            qz_q      <= '0;
            ypx_q     <= '0;
            ymx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            d2_q      <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            rz_q      <= '0;
            rt_q      <= '0;
            mul_req_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pz_q      <= pz_d;
            pt_q      <= pt_d;
            qyp_q     <= qyp_d;
            qym_q     <= qym_d;
            qt2d_q    <= qt2d_d;
            qz_q      <= qz_d;
            ypx_q     <= ypx_d;
            ymx_q     <= ymx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            d2_q      <= d2_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            rz_q      <= rz_d;
            rt_q      <= rt_d;
            mul_req_q <= mul_req_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mul_req   = mul_req_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign r_x       = rx_q;
    assign r_y       = ry_q;
    assign r_z       = rz_q;
    assign r_t       = rt_q;

endmodule
`default_nettype wire
